// File: rtl/mt_fetch_sched.sv
// mt_fetch_sched: per-thread PC file and round-robin fetch scheduler.
// Defining MT_FETCH_HALT_EN adds per-thread halt/resume control.
module mt_fetch_sched #(
   parameter int NUM_THREADS = 8,
   parameter int BITS_THREADS = $clog2(NUM_THREADS),
   parameter int ADDRESS_WIDTH = 32,
   parameter int INST_BYTES = 4,
   parameter longint unsigned RESET_BASE = 0,
   parameter longint unsigned RESET_STRIDE = 'h100
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_THREADS-1:0]   thread_en,
   input  logic                     stall,
   input  logic                     redirect_valid,
   input  logic [BITS_THREADS-1:0]  redirect_tid,
   input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
`ifdef MT_FETCH_HALT_EN
   input  logic                     halt_valid,
   input  logic [BITS_THREADS-1:0]  halt_tid,
   input  logic                     resume_valid,
   input  logic [BITS_THREADS-1:0]  resume_tid,
   output logic [NUM_THREADS-1:0]   halted,
`endif
   output logic                     fetch_valid,
   output logic [BITS_THREADS-1:0]  fetch_tid,
   output logic [ADDRESS_WIDTH-1:0] fetch_pc
);
   logic [ADDRESS_WIDTH-1:0] t_pc_q [NUM_THREADS];
   logic [BITS_THREADS-1:0]  last_tid_q;
   logic [BITS_THREADS-1:0]  sel;
   logic [BITS_THREADS-1:0]  cand;
   logic [NUM_THREADS-1:0]   elig;
   logic                     any;
`ifdef MT_FETCH_HALT_EN
   logic [NUM_THREADS-1:0] halted_q;
   assign halted = halted_q;
   assign elig = thread_en & ~halted_q;
   // Halt is written after resume so it wins on a same-tid collision.
   always_ff @(posedge clk) begin
      if (rst) begin
         halted_q <= '0;
      end else begin
         if (resume_valid && int'(resume_tid) < NUM_THREADS) halted_q[resume_tid] <= 1'b0;
         if (halt_valid && int'(halt_tid) < NUM_THREADS) halted_q[halt_tid] <= 1'b1;
      end
   end
`else
   assign elig = thread_en;
`endif
   // Scan farthest-first so the nearest eligible thread after last_tid wins.
   always_comb begin
      sel = last_tid_q;
      cand = '0;
      any = 1'b0;
      for (int k = NUM_THREADS; k >= 1; k--) begin
         cand = BITS_THREADS'((int'(last_tid_q) + k) % NUM_THREADS);
         if (elig[cand]) begin
            sel = cand;
            any = 1'b1;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_THREADS; i++)
            t_pc_q[i] <= ADDRESS_WIDTH'(RESET_BASE + RESET_STRIDE * 64'(i));
         last_tid_q <= BITS_THREADS'(NUM_THREADS - 1);
         fetch_valid <= 1'b0;
         fetch_tid <= '0;
         fetch_pc <= '0;
      end else begin
         if (!stall) begin
            fetch_valid <= any;
            if (any) begin
               fetch_tid <= sel;
               fetch_pc <= t_pc_q[sel];
               t_pc_q[sel] <= t_pc_q[sel] + ADDRESS_WIDTH'(INST_BYTES);
               last_tid_q <= sel;
            end
         end
         // Later write: redirect overrides the increment of the same thread.
         if (redirect_valid && int'(redirect_tid) < NUM_THREADS) t_pc_q[redirect_tid] <= redirect_pc;
      end
   end
endmodule

// File: doc/mt_fetch_sched.md
# mt_fetch_sched

Per-thread program-counter file and round-robin fetch scheduler for the barrel core's fetch stage. Each cycle it picks the next eligible hardware thread after the last one issued, presents that thread's PC to instruction memory, and advances the thread's PC. It applies branch and jump redirects from EX by thread ID, and supports per-thread start vectors, a thread-enable mask and a fetch stall.

## Interface
- NUM_THREADS, 8, number of hardware threads (>= 2; non-power-of-2 allowed)
- BITS_THREADS, $clog2(NUM_THREADS), thread-ID width
- ADDRESS_WIDTH, 32, PC width
- INST_BYTES, 4, sequential PC increment
- RESET_BASE, 0, start vector of thread 0
- RESET_STRIDE, 'h100, per-thread start-vector spacing
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- thread_en  in  NUM_THREADS  bit i = 1: thread i may be scheduled
- stall  in  1  fetch stage stalled; hold outputs and scheduling state
- redirect_valid  in  1  EX redirect strobe
- redirect_tid  in  BITS_THREADS  thread being redirected
- redirect_pc  in  ADDRESS_WIDTH  new PC for redirect_tid
- fetch_valid  out  1  fetch_tid/fetch_pc hold a valid fetch
- fetch_tid  out  BITS_THREADS  issued thread
- fetch_pc  out  ADDRESS_WIDTH  issued PC

## Operation
- PC file: t_pc[i], one per thread. On reset, t_pc[i] = RESET_BASE + i*RESET_STRIDE, truncated to ADDRESS_WIDTH.
- Eligible(i) = thread_en[i] & ~halted[i], with i < NUM_THREADS. halted is 0 when the halt feature is not compiled in.
- Scheduler pointer last_tid resets to NUM_THREADS-1, so the first issue after reset is the lowest eligible thread at or above 0.
- Selection (combinational) = the first eligible thread scanning last_tid+1, last_tid+2, …, wrapping NUM_THREADS-1 -> 0, ending with last_tid itself. A single eligible thread is therefore issued every cycle.
- Issue cycle (stall = 0, some thread eligible):
  - fetch_valid <= 1
  - fetch_tid <= sel
  - fetch_pc <= t_pc[sel]
  - t_pc[sel] <= t_pc[sel] + INST_BYTES, modulo 2^ADDRESS_WIDTH
  - last_tid <= sel
- No eligible thread (stall = 0): fetch_valid <= 0. fetch_tid, fetch_pc and last_tid hold. No PC changes except redirects.
- Stall: all outputs, last_tid and the increment path hold. Redirects still write the PC file.
- Redirect: t_pc[redirect_tid] <= redirect_pc.
  - Redirect beats the increment when redirect_tid == sel on the same edge.
  - The fetch registered on that edge carries the old PC. Squashing it downstream is the pipeline's job, done by tid.
  - redirect_tid >= NUM_THREADS is ignored.
- Reset mid-operation: every state element returns to its reset value on the next edge. Outputs reset to fetch_valid = 0, fetch_tid = 0, fetch_pc = 0.

## Timing
- One-cycle latency: selection uses cycle-N state and is visible on the outputs after edge N.
- A thread_en change sampled at edge N affects the selection made in cycle N.
- A redirect sampled at edge N is visible in the first fetch of that thread registered at edge N+1 or later.
- One fetch per cycle at most. With k eligible threads and no stall, each thread issues exactly once every k cycles.

## Configuration
- MT_FETCH_HALT_EN defined: adds the following.
  - Ports halt_valid in 1, halt_tid in BITS_THREADS, resume_valid in 1, resume_tid in BITS_THREADS, halted out NUM_THREADS.
  - halted[halt_tid] <= 1 on halt_valid; halted[resume_tid] <= 0 on resume_valid. Halt wins if both target the same tid on the same edge.
  - halted resets to all 0.
  - Halt/resume take effect on the selection in the following cycle and are applied even during stall.
  - A halted thread keeps its PC and still accepts redirects.
- MT_FETCH_HALT_EN undefined: these ports and state are absent; eligibility = thread_en only.

## Test plan
- Round-robin: reset, NUM_THREADS=4, thread_en=4'b1111, no stall -> fetch (tid,pc) = (0,0x000), (1,0x100), (2,0x200), (3,0x300), (0,0x004), (1,0x104).
- Sparse mask: thread_en=4'b1010 -> tids 1,3,1,3 with PCs 0x100,0x300,0x104,0x304. Then thread_en=0 -> fetch_valid=0 and PCs frozen.
- Redirect collision: redirect tid 2 to 0x8000 on the edge where tid 2 issues -> that fetch shows the old PC; tid 2's next fetch = 0x8000, the one after = 0x8004.
- Stall: stall high for 3 cycles mid-stream -> outputs are held constant, no PC advances, and the stream resumes with the next thread in order. A redirect during the stall is reflected after the stall.
- Wrap: ADDRESS_WIDTH=8, t_pc forced via redirect to 0xFC -> next fetch 0xFC, following fetch 0x00. Assert rst mid-stream -> next cycle fetch_valid=0 and PCs back to start vectors.
- MT_FETCH_HALT_EN: halt tid 1 with 4 threads enabled -> sequence 0,2,3,0. Simultaneous halt and resume of tid 1 -> stays halted. Resume -> tid 1 reappears with its preserved PC.
